// File: rtl/morse_matcher_if.sv
// Handshake bundle between the Morse decoder/game top and the player-2 matcher.
// The matcher is the slave: it consumes symbol/control pulses and drives status.
interface morse_matcher_if #(
   parameter int SYMBOLS   = 5,
   parameter int MAX_TRIES = 3
);
   localparam int W  = 2 * SYMBOLS;
   localparam int CW = $clog2(SYMBOLS + 1);
   localparam int TW = $clog2(MAX_TRIES + 1);

   logic          start;
   logic          ld_dot;
   logic          ld_line;
   logic          done_input;
   logic [W-1:0]  target;
   logic [W-1:0]  q;
   logic [CW-1:0] sym_count;
   logic [TW-1:0] tries_left;
   logic          correct;
   logic          wrong;
   logic          complete;
   logic          failed;

   modport master (
      output start, ld_dot, ld_line, done_input, target,
      input  q, sym_count, tries_left, correct, wrong, complete, failed
   );

   modport slave (
      input  start, ld_dot, ld_line, done_input, target,
      output q, sym_count, tries_left, correct, wrong, complete, failed
   );
endinterface

// File: rtl/morse_matcher.sv
// Player-2 entry checker: packs dot/line pulses into a left-justified guess, checks
// each symbol against the latched target and tracks a bounded retry budget.
module morse_matcher #(
   parameter int SYMBOLS   = 5,
   parameter int MAX_TRIES = 3,
   parameter int STRICT    = 0
) (
   input logic            clock,
   input logic            resetn,
   morse_matcher_if.slave bus
);
   localparam int W  = 2 * SYMBOLS;
   localparam int CW = $clog2(SYMBOLS + 1);
   localparam int TW = $clog2(MAX_TRIES + 1);

   typedef enum logic [1:0] {IDLE, ENTRY, MATCH, LOCKED} state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  target_q, target_d;
   logic [W-1:0]  q_q, q_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tries_q, tries_d;
   logic          err_q, err_d;
   logic          correct_q, correct_d;
   logic          wrong_q, wrong_d;

   // Word length counts leading non-empty slots; anything after the first 00 is ignored.
   function automatic logic [CW-1:0] word_len(input logic [W-1:0] w);
      logic [CW-1:0] n;
      logic          stop;
      n    = '0;
      stop = 1'b0;
      for (int i = 0; i < SYMBOLS; i++) begin
         if (w[W-1-2*i -: 2] == 2'b00) stop = 1'b1;
         else if (!stop)               n = n + 1'b1;
      end
      return n;
   endfunction

   logic [CW-1:0] target_len;
   assign target_len = word_len(target_q);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values; the async reset also clears the latched target.
   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         state_q   <= IDLE;
         target_q  <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         tries_q   <= '0;
         err_q     <= 1'b0;
         correct_q <= 1'b0;
         wrong_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         tries_q   <= tries_d;
         err_q     <= err_d;
         correct_q <= correct_d;
         wrong_q   <= wrong_d;
      end
   end

   logic       sym_evt;
   logic       sym_bad;
   logic       fail;
   logic [1:0] sym;
   logic [1:0] exp_slot;

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      tries_d   = tries_q;
      err_d     = err_q;
      correct_d = 1'b0;
      wrong_d   = 1'b0;
      sym_evt   = bus.ld_dot ^ bus.ld_line;
      sym       = bus.ld_dot ? 2'b01 : 2'b11;
      exp_slot  = 2'b00;
      sym_bad   = 1'b0;
      fail      = 1'b0;

      if (bus.start) begin
         target_d = bus.target;
         q_d      = '0;
         cnt_d    = '0;
         err_d    = 1'b0;
         if (word_len(bus.target) == '0) begin
            state_d = IDLE;
            tries_d = '0;
         end else begin
            state_d = ENTRY;
            tries_d = TW'(MAX_TRIES);
         end
      end else if (state_q == ENTRY) begin
         if (bus.done_input) begin
            if (!err_q && cnt_q == target_len) state_d = MATCH;
            else                               fail    = 1'b1;
         end else if (sym_evt) begin
            if (cnt_q < CW'(SYMBOLS)) begin
               for (int i = 0; i < SYMBOLS; i++) begin
                  if (cnt_q == CW'(i)) begin
                     q_d[W-1-2*i -: 2] = sym;
                     exp_slot          = target_q[W-1-2*i -: 2];
                  end
               end
               cnt_d   = cnt_q + 1'b1;
               sym_bad = (sym != exp_slot);
            end else begin
               sym_bad = 1'b1;
            end
            correct_d = !sym_bad;
            wrong_d   = sym_bad;
            if (sym_bad) err_d = 1'b1;
            if (STRICT != 0 && sym_bad) fail = 1'b1;
         end

         // The last failure locks the round with the guess left on display.
         if (fail) begin
            tries_d = tries_q - 1'b1;
            if (tries_q == TW'(1)) begin
               state_d = LOCKED;
            end else begin
               q_d   = '0;
               cnt_d = '0;
               err_d = 1'b0;
            end
         end
      end
   end

   assign bus.q          = q_q;
   assign bus.sym_count  = cnt_q;
   assign bus.tries_left = tries_q;
   assign bus.correct    = correct_q;
   assign bus.wrong      = wrong_q;
   assign bus.complete   = (state_q == MATCH);
   assign bus.failed     = (state_q == LOCKED);
endmodule

// File: tb/tb_morse_matcher.sv
// Scoreboard bench for morse_matcher: stimulus pushes hand-computed post-edge outputs,
// a monitor pops and compares them after each edge. DUT0 is lenient, DUT1 strict.
module tb_morse_matcher;
   localparam logic [9:0] T1 = 10'b0111010000;
   localparam logic [9:0] T2 = 10'b0100000000;

   localparam logic [3:0] I_NONE  = 4'b0000;
   localparam logic [3:0] I_START = 4'b1000;
   localparam logic [3:0] I_DOT   = 4'b0100;
   localparam logic [3:0] I_LINE  = 4'b0010;
   localparam logic [3:0] I_DONE  = 4'b0001;

   localparam logic [3:0] F_NONE = 4'b0000;
   localparam logic [3:0] F_C    = 4'b1000;
   localparam logic [3:0] F_W    = 4'b0100;
   localparam logic [3:0] F_CMP  = 4'b0010;
   localparam logic [3:0] F_FL   = 4'b0001;

   typedef struct {
      logic [9:0] q;
      logic [2:0] cnt;
      logic [1:0] tries;
      logic [3:0] flags;
   } exp_t;

   logic clock = 1'b0;
   logic resetn = 1'b1;
   always #5 clock = ~clock;

   morse_matcher_if #(.SYMBOLS(5), .MAX_TRIES(3)) bus0 ();
   morse_matcher_if #(.SYMBOLS(5), .MAX_TRIES(3)) bus1 ();

   morse_matcher #(.SYMBOLS(5), .MAX_TRIES(3), .STRICT(0)) dut0 (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus0.slave)
   );

   morse_matcher #(.SYMBOLS(5), .MAX_TRIES(3), .STRICT(1)) dut1 (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus1.slave)
   );

   exp_t sb0[$];
   exp_t sb1[$];
   int   compared   = 0;
   int   mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_out(input string tag, input exp_t e, input logic [9:0] q,
                          input logic [2:0] cnt, input logic [1:0] tries,
                          input logic c, input logic w, input logic cmp, input logic fl);
      check({tag, " q"},          q,                e.q);
      check({tag, " sym_count"},  cnt,              e.cnt);
      check({tag, " tries_left"}, tries,            e.tries);
      check({tag, " pulses"},     {c, w, cmp, fl},  e.flags);
   endtask

   // Monitor: one expected entry is pending per driven cycle; compare just after the edge.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (sb0.size() > 0) begin
            exp_t e;
            e = sb0.pop_front();
            cmp_out("dut0", e, bus0.q, bus0.sym_count, bus0.tries_left,
                    bus0.correct, bus0.wrong, bus0.complete, bus0.failed);
         end
         if (sb1.size() > 0) begin
            exp_t e;
            e = sb1.pop_front();
            cmp_out("dut1", e, bus1.q, bus1.sym_count, bus1.tries_left,
                    bus1.correct, bus1.wrong, bus1.complete, bus1.failed);
         end
      end
   end

   task automatic idle_inputs();
      {bus0.start, bus0.ld_dot, bus0.ld_line, bus0.done_input} = 4'b0000;
      {bus1.start, bus1.ld_dot, bus1.ld_line, bus1.done_input} = 4'b0000;
      bus0.target = '0;
      bus1.target = '0;
   endtask

   // Drive one cycle on the selected DUT and queue the outputs expected after that edge.
   task automatic step(input bit sel, input logic [3:0] in, input logic [9:0] tgt,
                       input logic [9:0] eq, input int ecnt, input int etries,
                       input logic [3:0] eflags);
      exp_t e;
      @(negedge clock);
      {bus0.start, bus0.ld_dot, bus0.ld_line, bus0.done_input} = sel ? 4'b0000 : in;
      {bus1.start, bus1.ld_dot, bus1.ld_line, bus1.done_input} = sel ? in : 4'b0000;
      bus0.target = tgt;
      bus1.target = tgt;
      e.q     = eq;
      e.cnt   = 3'(ecnt);
      e.tries = 2'(etries);
      e.flags = eflags;
      if (sel) sb1.push_back(e);
      else     sb0.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      repeat (3) @(negedge clock);
      resetn = 1'b0;

      // Reset state on both instances
      step(0, I_NONE, 10'b0, 10'b0, 0, 0, F_NONE);
      step(1, I_NONE, 10'b0, 10'b0, 0, 0, F_NONE);

      // Lenient: dot line dot then done wins the round
      step(0, I_START, T1, 10'b0,          0, 3, F_NONE);
      step(0, I_DOT,   T1, 10'b0100000000, 1, 3, F_C);
      step(0, I_LINE,  T1, 10'b0111000000, 2, 3, F_C);
      step(0, I_DOT,   T1, 10'b0111010000, 3, 3, F_C);
      step(0, I_DONE,  T1, 10'b0111010000, 3, 3, F_CMP);
      step(0, I_NONE,  T1, 10'b0111010000, 3, 3, F_CMP);
      step(0, I_DOT,   T1, 10'b0111010000, 3, 3, F_CMP);

      // Lenient: three failed attempts lock the round
      step(0, I_START, T1, 10'b0,          0, 3, F_NONE);
      step(0, I_DOT,   T1, 10'b0100000000, 1, 3, F_C);
      step(0, I_DOT,   T1, 10'b0101000000, 2, 3, F_W);
      step(0, I_DOT,   T1, 10'b0101010000, 3, 3, F_C);
      step(0, I_DONE,  T1, 10'b0,          0, 2, F_NONE);
      step(0, I_DONE,  T1, 10'b0,          0, 1, F_NONE);
      step(0, I_DOT,   T1, 10'b0100000000, 1, 1, F_C);
      step(0, I_DONE,  T1, 10'b0100000000, 1, 0, F_FL);
      step(0, I_NONE,  T1, 10'b0100000000, 1, 0, F_FL);
      step(0, I_DOT,   T1, 10'b0100000000, 1, 0, F_FL);
      step(0, I_START, T1, 10'b0,          0, 3, F_NONE);

      // Strict: a wrong symbol fails the attempt at once
      step(1, I_START, T1, 10'b0,          0, 3, F_NONE);
      step(1, I_LINE,  T1, 10'b0,          0, 2, F_W);
      step(1, I_DOT,   T1, 10'b0100000000, 1, 2, F_C);
      step(1, I_DOT,   T1, 10'b0,          0, 1, F_W);
      step(1, I_NONE,  T1, 10'b0,          0, 1, F_NONE);

      // Length mismatch, then overflow past five symbols
      step(0, I_START, T2, 10'b0,          0, 3, F_NONE);
      step(0, I_DOT,   T2, 10'b0100000000, 1, 3, F_C);
      step(0, I_LINE,  T2, 10'b0111000000, 2, 3, F_W);
      step(0, I_DONE,  T2, 10'b0,          0, 2, F_NONE);
      step(0, I_DOT,   T2, 10'b0100000000, 1, 2, F_C);
      step(0, I_DOT,   T2, 10'b0101000000, 2, 2, F_W);
      step(0, I_DOT,   T2, 10'b0101010000, 3, 2, F_W);
      step(0, I_LINE,  T2, 10'b0101011100, 4, 2, F_W);
      step(0, I_DOT,   T2, 10'b0101011101, 5, 2, F_W);
      step(0, I_LINE,  T2, 10'b0101011101, 5, 2, F_W);
      step(0, I_NONE,  T2, 10'b0101011101, 5, 2, F_NONE);

      // Simultaneous inputs and priorities
      step(0, I_START,          T1, 10'b0,          0, 3, F_NONE);
      step(0, I_DOT | I_LINE,   T1, 10'b0,          0, 3, F_NONE);
      step(0, I_DOT,            T1, 10'b0100000000, 1, 3, F_C);
      step(0, I_LINE,           T1, 10'b0111000000, 2, 3, F_C);
      step(0, I_DONE | I_DOT,   T1, 10'b0,          0, 2, F_NONE);
      step(0, I_DOT | I_LINE,   T1, 10'b0,          0, 2, F_NONE);
      step(0, I_START | I_DONE, T1, 10'b0,          0, 3, F_NONE);

      // Asynchronous reset mid-entry with two symbols in and a pulse showing
      step(0, I_DOT,  T1, 10'b0100000000, 1, 3, F_C);
      step(0, I_LINE, T1, 10'b0111000000, 2, 3, F_C);
      @(posedge clock);
      #3;
      resetn = 1'b1;
      #1;
      check("async reset q",          bus0.q,          10'b0);
      check("async reset sym_count",  bus0.sym_count,  3'd0);
      check("async reset tries_left", bus0.tries_left, 2'd0);
      check("async reset pulses",
            {bus0.correct, bus0.wrong, bus0.complete, bus0.failed}, 4'b0000);
      idle_inputs();
      repeat (2) @(negedge clock);
      resetn = 1'b0;

      // After reset: symbols ignored in IDLE, empty target does not start a round
      step(0, I_DOT,   T1,    10'b0, 0, 0, F_NONE);
      step(0, I_START, 10'b0, 10'b0, 0, 0, F_NONE);
      step(0, I_DOT,   T1,    10'b0, 0, 0, F_NONE);
      step(0, I_NONE,  T1,    10'b0, 0, 0, F_NONE);

      repeat (3) @(posedge clock);
      #2;
      check("dut0 scoreboard drained", sb0.size(), 0);
      check("dut1 scoreboard drained", sb1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
